fwd_scoreboard_unit: RTL and testbench
======================================

// Module: fwd_scoreboard_unit
// PURPOSE
//  Parametrised forwarding/hazard unit for the pipelined CPU. Tracks in-flight register writes itself in
//  a DEPTH-entry shadow pipeline (entry 1 = EX/MEM, 2 = MEM/WB, ...), one entry per stage after EX.
//  Produces a per-operand forward select for NUM_SRC operands and flags load-use hazards.
//  When a hazard is flagged, the unit inserts its own bubble. Sits beside the EX stage.
//  The caller only presents the instruction leaving EX.
// PARAMETERS
//  ADDR_W    5  register address width
//  NUM_SRC   2  source operands checked per cycle (rs, rt, ...)
//  DEPTH     2  forwarding stages after EX (>=1)
//  LOAD_LAT  1  load data is forwardable only from entry k > LOAD_LAT (0 <= LOAD_LAT < DEPTH)
//  SEL_W = $clog2(DEPTH+1), derived localparam, not overridable
// PORTS
//  clk_i          in   1                 clock
//  rst_i          in   1                 synchronous reset, active-high
//  adv_i          in   1                 pipeline advances this cycle; 0 = all entries hold
//  ex_valid_i     in   1                 a real instruction is in EX (0 = bubble)
//  ex_rd_addr_i   in   ADDR_W            destination of the EX instruction
//  ex_regwrite_i  in   1                 EX instruction writes the register file
//  ex_memread_i   in   1                 EX instruction is a load
//  src_addr_i     in   NUM_SRC*ADDR_W    source addresses of the EX instruction, operand n at [n*ADDR_W +: ADDR_W]
//  fwd_sel_o      out  NUM_SRC*SEL_W     per operand: 0 = register file, k = entry k
//  hazard_o       out  1                 some operand's producer is not yet forwardable
//  stall_cnt_o    out  32                hazard cycle count (only with FWD_STATS_EN)
// BEHAVIOUR
//  - Entry = {valid, rd, load}. Reset: all entries invalid; fwd_sel_o = 0, hazard_o = 0, stall_cnt_o = 0.
//  - Update on clk_i when adv_i=1:
//      entry[k] <= entry[k-1] for k >= 2;
//      entry[1] <= {ex_valid_i & ex_regwrite_i & ~hazard_o, ex_rd_addr_i, ex_memread_i}.
//    When adv_i=0, all entries hold. rst_i overrides adv_i.
//  - An entry matches operand n when: valid, rd == src_n, and rd != 0. Address 0 never forwards.
//  - The smallest matching k (youngest producer) wins. fwd_sel_o is combinational from the entries and src_addr_i.
//  - Ready rule: entry k is ready if !load or k > LOAD_LAT.
//  - If the winning match is not ready: fwd_sel_n = 0 and hazard_o = 1, even if an older entry also matches.
//  - hazard_o is the OR over all operands and is combinational.
//  - On hazard with adv_i=1, the block writes a bubble into entry 1 and the caller holds ID/EX.
//    Next cycle the load sits at entry 2, so the operand selects 2 when DEPTH=2 and LOAD_LAT=1.
//  - DEPTH=2 / LOAD_LAT=1 encoding matches the legacy forwarding encoding: 01 = EX/MEM, 10 = MEM/WB.
//  - Both operands may match the same entry. Simultaneous hazard on several operands yields one hazard_o pulse per cycle.
// CONFIGURATION
//  FWD_STATS_EN defined: stall_cnt_o counts cycles with hazard_o & adv_i. It is 32-bit saturating
//    and cleared by rst_i.
//  FWD_STATS_EN undefined: stall_cnt_o is tied to 0 and no counter flops are generated.
// STRUCTURE
//  - Package fwd_pkg: fwd_entry_t struct {valid, rd[ADDR_W], load}, and FWD_SEL_RF = 0.
//  - Sub-module fwd_src_match: priority encoder over DEPTH entries for one operand, outputs {sel, not_ready}.
//    Instantiated NUM_SRC times in a generate loop; the shadow pipeline and counter live in the top.
// TESTING (defaults: DEPTH=2, LOAD_LAT=1, NUM_SRC=2)
//  1. rst_i=1 for 2 cycles, with random inputs.
//     -> fwd_sel_o=0, hazard_o=0, stall_cnt_o=0.
//  2. add r3 in EX, adv_i=1; then hold src0=3 across later cycles.
//     -> sel0=1 in cycle+1, sel0=2 in cycle+2, sel0=0 in cycle+3.
//  3. Back-to-back writes to r5, then src1=5.
//     -> sel1=1 (youngest wins over entry 2).
//  4. lw r4 in EX, then src0=4.
//     -> hazard_o=1, sel0=0, entry 1 becomes a bubble.
//     -> next cycle: sel0=2, hazard_o=0; stall_cnt_o=1 with FWD_STATS_EN.
//  5. Write to r0 with regwrite=1, then src0=src1=0.
//     -> sel=0 on both, hazard_o=0.
//  6. adv_i=0 for 3 cycles after a write to r7, with src0=7.
//     -> sel0 stays 1 throughout; rst_i asserted mid-hold clears it to 0 next cycle.

Source files
------------

// File: rtl/fwd_pkg.sv
// Shared types for the forwarding scoreboard: shadow-pipeline entry layout and select encodings.
// Used by fwd_scoreboard_unit (optional FWD_STATS_EN stall counter) and fwd_src_match.
package fwd_pkg;

    // Stored rd width; wide enough for any practical register address width, zero-extended on entry.
    localparam int FWD_RD_W   = 16;
    localparam int FWD_SEL_RF = 0;

    typedef struct packed {
        logic                valid;
        logic [FWD_RD_W-1:0] rd;
        logic                load;
    } fwd_entry_t;

    function automatic fwd_entry_t make_entry(input logic valid, input logic [FWD_RD_W-1:0] rd,
                                              input logic load);
        fwd_entry_t e;
        e.valid = valid;
        e.rd    = rd;
        e.load  = load;
        return e;
    endfunction

endpackage

// File: rtl/fwd_src_match.sv
// Per-operand priority encoder: picks the youngest matching in-flight write and reports
// whether that producer can already supply its data.
module fwd_src_match
    import fwd_pkg::*;
#(
    parameter int ADDR_W   = 5,
    parameter int DEPTH    = 2,
    parameter int LOAD_LAT = 1,
    parameter int SEL_W    = 2
) (
    input  fwd_entry_t [DEPTH:1]  entries,
    input  logic [ADDR_W-1:0]     src,
    output logic [SEL_W-1:0]      sel,
    output logic                  not_ready
);

    logic [FWD_RD_W-1:0] src_ext;
    logic [DEPTH:1]      hit;
    logic [DEPTH:1]      ready;

    assign src_ext = FWD_RD_W'(src);

    genvar gi;
    generate
        for (gi = 1; gi <= DEPTH; gi++) begin : g_entry
            // Register 0 is hard-wired, so it never participates in forwarding.
            assign hit[gi]   = entries[gi].valid && (entries[gi].rd == src_ext) && (src_ext != '0);
            assign ready[gi] = !entries[gi].load || (gi > LOAD_LAT);
        end
    endgenerate

    logic found;

    always_comb begin
        sel       = SEL_W'(FWD_SEL_RF);
        not_ready = 1'b0;
        found     = 1'b0;
        for (int k = 1; k <= DEPTH; k++) begin
            if (!found && hit[k]) begin
                found = 1'b1;
                // An unready youngest producer blocks forwarding even if an older entry matches.
                if (ready[k]) begin
                    sel = SEL_W'(k);
                end else begin
                    not_ready = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/fwd_scoreboard_unit.sv
// Forwarding/hazard unit with its own shadow pipeline of in-flight register writes.
// Define FWD_STATS_EN to build the saturating hazard-cycle counter on stall_cnt_o.
module fwd_scoreboard_unit
    import fwd_pkg::*;
#(
    parameter  int ADDR_W   = 5,
    parameter  int NUM_SRC  = 2,
    parameter  int DEPTH    = 2,
    parameter  int LOAD_LAT = 1,
    localparam int SEL_W    = $clog2(DEPTH + 1)
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        adv_i,
    input  logic                        ex_valid_i,
    input  logic [ADDR_W-1:0]           ex_rd_addr_i,
    input  logic                        ex_regwrite_i,
    input  logic                        ex_memread_i,
    input  logic [NUM_SRC*ADDR_W-1:0]   src_addr_i,
    output logic [NUM_SRC*SEL_W-1:0]    fwd_sel_o,
    output logic                        hazard_o,
    output logic [31:0]                 stall_cnt_o
);

    fwd_entry_t [DEPTH:1] entry_reg;
    fwd_entry_t [DEPTH:1] entry_next;
    logic [NUM_SRC-1:0]   not_ready;

    // Shadow pipeline: entry 1 takes the instruction leaving EX, a bubble while stalling.
    always_comb begin
        entry_next = entry_reg;
        if (adv_i) begin
            for (int k = DEPTH; k >= 2; k--) begin
                entry_next[k] = entry_reg[k-1];
            end
            entry_next[1] = make_entry(ex_valid_i & ex_regwrite_i & ~hazard_o,
                                       FWD_RD_W'(ex_rd_addr_i), ex_memread_i);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            entry_reg <= '0;
        end else begin
            entry_reg <= entry_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
            fwd_src_match #(
                .ADDR_W   (ADDR_W),
                .DEPTH    (DEPTH),
                .LOAD_LAT (LOAD_LAT),
                .SEL_W    (SEL_W)
            ) u_match (
                .entries   (entry_reg),
                .src       (src_addr_i[gi*ADDR_W +: ADDR_W]),
                .sel       (fwd_sel_o[gi*SEL_W +: SEL_W]),
                .not_ready (not_ready[gi])
            );
        end
    endgenerate

    assign hazard_o = |not_ready;

`ifdef FWD_STATS_EN
    logic [31:0] stall_cnt_reg;
    logic [31:0] stall_cnt_next;

    always_comb begin
        stall_cnt_next = stall_cnt_reg;
        if (hazard_o && adv_i && (stall_cnt_reg != '1)) begin
            stall_cnt_next = stall_cnt_reg + 32'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_reg <= '0;
        end else begin
            stall_cnt_reg <= stall_cnt_next;
        end
    end

    assign stall_cnt_o = stall_cnt_reg;
`else
    assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_fwd_scoreboard_unit.sv
// Directed bench for fwd_scoreboard_unit (DEPTH=2, LOAD_LAT=1, NUM_SRC=2); expected outputs are queued
// when each step is driven and popped when the step's outputs are sampled.
module tb_fwd_scoreboard_unit;

    localparam int ADDR_W  = 5;
    localparam int NUM_SRC = 2;
    localparam int SEL_W   = 2;

    logic                      clk_i = 1'b0;
    logic                      rst_i;
    logic                      adv_i;
    logic                      ex_valid_i;
    logic [ADDR_W-1:0]         ex_rd_addr_i;
    logic                      ex_regwrite_i;
    logic                      ex_memread_i;
    logic [NUM_SRC*ADDR_W-1:0] src_addr_i;
    logic [NUM_SRC*SEL_W-1:0]  fwd_sel_o;
    logic                      hazard_o;
    logic [31:0]               stall_cnt_o;

    fwd_scoreboard_unit dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .adv_i         (adv_i),
        .ex_valid_i    (ex_valid_i),
        .ex_rd_addr_i  (ex_rd_addr_i),
        .ex_regwrite_i (ex_regwrite_i),
        .ex_memread_i  (ex_memread_i),
        .src_addr_i    (src_addr_i),
        .fwd_sel_o     (fwd_sel_o),
        .hazard_o      (hazard_o),
        .stall_cnt_o   (stall_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [SEL_W-1:0] sel0;
        logic [SEL_W-1:0] sel1;
        logic             haz;
        logic [31:0]      stall;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          passed = 0;
    int          step_no = 0;
    logic [31:0] model_stall = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) passed++;
        else $error("FAIL %s step %0d: got %0h expected %0h", tag, step_no, obs, exp_v);
    endtask

    // One pipeline cycle: drive, queue the expectation, sample at negedge, then clock.
    task automatic step(input logic rst, input logic adv, input logic v, input logic [ADDR_W-1:0] rd,
                        input logic rw, input logic mr, input logic [ADDR_W-1:0] s0,
                        input logic [ADDR_W-1:0] s1, input logic [SEL_W-1:0] e0,
                        input logic [SEL_W-1:0] e1, input logic eh);
        exp_t e;
        exp_t got;
        rst_i = rst; adv_i = adv; ex_valid_i = v; ex_rd_addr_i = rd;
        ex_regwrite_i = rw; ex_memread_i = mr; src_addr_i = {s1, s0};
        e.sel0 = e0; e.sel1 = e1; e.haz = eh;
`ifdef FWD_STATS_EN
        e.stall = model_stall;
`else
        e.stall = 32'd0;
`endif
        exp_q.push_back(e);
        @(negedge clk_i);
        step_no++;
        if (exp_q.size() == 0) begin
            checks++;
            $error("FAIL scoreboard step %0d: got empty queue expected entry", step_no);
        end else begin
            got = exp_q.pop_front();
            check("sel0",  32'(fwd_sel_o[SEL_W-1:0]),       32'(got.sel0));
            check("sel1",  32'(fwd_sel_o[2*SEL_W-1:SEL_W]), 32'(got.sel1));
            check("hazard", 32'(hazard_o),                  32'(got.haz));
            check("stall", stall_cnt_o,                     got.stall);
        end
        $display("step %0d rst=%0b adv=%0b src=%0d/%0d sel=%0d/%0d haz=%0b stall=%0d",
                 step_no, rst, adv, s0, s1, fwd_sel_o[SEL_W-1:0], fwd_sel_o[2*SEL_W-1:SEL_W],
                 hazard_o, stall_cnt_o);
        if (rst) model_stall = 0;
        else if (eh && adv) model_stall = model_stall + 1;
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        // Reset with random inputs on the bus.
        rst_i = 1'b1; adv_i = 1'($urandom); ex_valid_i = 1'($urandom);
        ex_rd_addr_i = ADDR_W'($urandom); ex_regwrite_i = 1'($urandom);
        ex_memread_i = 1'($urandom); src_addr_i = (NUM_SRC*ADDR_W)'($urandom);
        @(posedge clk_i); #1;
        adv_i = 1'($urandom); ex_rd_addr_i = ADDR_W'($urandom);
        @(posedge clk_i); #1;
        step(1, 1, 1, 5'd9, 1, 1, 5'd9, 5'd9, 0, 0, 0);

        // add r3 ages through EX/MEM, MEM/WB, then retires.
        step(0, 1, 1, 5'd3, 1, 0, 5'd0, 5'd0, 0, 0, 0);
        step(0, 1, 0, 5'd0, 0, 0, 5'd3, 5'd0, 1, 0, 0);
        step(0, 1, 0, 5'd0, 0, 0, 5'd3, 5'd0, 2, 0, 0);
        step(0, 1, 0, 5'd0, 0, 0, 5'd3, 5'd0, 0, 0, 0);

        // Back-to-back writes to r5: youngest wins.
        step(0, 1, 1, 5'd5, 1, 0, 5'd0, 5'd0, 0, 0, 0);
        step(0, 1, 1, 5'd5, 1, 0, 5'd0, 5'd0, 0, 0, 0);
        step(0, 1, 0, 5'd0, 0, 0, 5'd0, 5'd5, 0, 1, 0);
        step(0, 1, 0, 5'd0, 0, 0, 5'd0, 5'd5, 0, 2, 0);

        // Load-use: hazard, bubble, then forward from MEM/WB.
        step(0, 1, 1, 5'd4, 1, 1, 5'd0, 5'd0, 0, 0, 0);
        step(0, 1, 1, 5'd9, 1, 0, 5'd4, 5'd0, 0, 0, 1);
        step(0, 1, 1, 5'd9, 1, 0, 5'd4, 5'd0, 2, 0, 0);

        // Writes to r0 never forward.
        step(0, 1, 1, 5'd0, 1, 0, 5'd0, 5'd0, 0, 0, 0);
        step(0, 1, 0, 5'd0, 0, 0, 5'd0, 5'd0, 0, 0, 0);

        // Both operands hit the same entry.
        step(0, 1, 1, 5'd6, 1, 0, 5'd0, 5'd0, 0, 0, 0);
        step(0, 1, 0, 5'd0, 0, 0, 5'd6, 5'd6, 1, 1, 0);

        // Hold with adv_i=0, then reset mid-hold.
        step(0, 1, 1, 5'd7, 1, 0, 5'd0, 5'd0, 0, 0, 0);
        step(0, 0, 1, 5'd8, 1, 0, 5'd7, 5'd0, 1, 0, 0);
        step(0, 0, 0, 5'd0, 0, 0, 5'd7, 5'd0, 1, 0, 0);
        step(0, 0, 0, 5'd0, 0, 0, 5'd7, 5'd0, 1, 0, 0);
        step(1, 0, 0, 5'd0, 0, 0, 5'd7, 5'd0, 1, 0, 0);
        step(0, 0, 0, 5'd0, 0, 0, 5'd7, 5'd0, 0, 0, 0);

        // Hazard while held does not count; hazard with advance does.
        step(0, 1, 1, 5'd8, 1, 1, 5'd0, 5'd0, 0, 0, 0);
        step(0, 0, 1, 5'd2, 1, 0, 5'd1, 5'd8, 0, 0, 1);
        step(0, 0, 1, 5'd2, 1, 0, 5'd1, 5'd8, 0, 0, 1);
        step(0, 1, 1, 5'd2, 1, 0, 5'd1, 5'd8, 0, 0, 1);
        step(0, 1, 1, 5'd2, 1, 0, 5'd1, 5'd8, 0, 2, 0);
        step(0, 1, 0, 5'd0, 0, 0, 5'd2, 5'd2, 1, 1, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
